sensor_conditioner: RTL

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/sensor_conditioner_if.sv | 27 ++
 rtl/sensor_conditioner.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner_if.sv
// Signal bundle between the raw sensor front end and the home controller.
// The slave side is the conditioner; the master side supplies raw samples and consumes the results.
interface sensor_conditioner_if;
  logic       raw_fd;
  logic       raw_rd;
  logic       raw_w;
  logic       raw_fa;
  logic [6:0] raw_temp;
  logic       temp_valid;
  logic       sfd;
  logic       srd;
  logic       sw;
  logic       sfa;
  logic [6:0] st;
  logic       st_ready;
  logic       sensor_fault;

  modport master (
    output raw_fd, raw_rd, raw_w, raw_fa, raw_temp, temp_valid,
    input  sfd, srd, sw, sfa, st, st_ready, sensor_fault
  );

  modport slave (
    input  raw_fd, raw_rd, raw_w, raw_fa, raw_temp, temp_valid,
    output sfd, srd, sw, sfa, st, st_ready, sensor_fault
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Conditions raw door/window/fire contacts (sync + debounce) and produces a
// 4-sample moving average of validated temperature samples with a sticky fault flag.
module sensor_conditioner #(
  parameter int         DB_CYCLES = 4,
  parameter int         FA_CYCLES = 2,
  parameter logic [6:0] ST_INIT   = 7'd25,
  parameter logic [6:0] TEMP_MAX  = 7'd100
) (
  input logic            clk,
  input logic            rst,
  sensor_conditioner_if.slave sif
);

  localparam int MAX_CYC = (DB_CYCLES > FA_CYCLES) ? DB_CYCLES : FA_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] FA_LAST = CNT_W'(FA_CYCLES - 1);

  // Bit order: 0 front door, 1 rear door, 2 window, 3 fire.
  logic [3:0] raw_vec;
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] out_vec;

  assign raw_vec = {sif.raw_fa, sif.raw_w, sif.raw_rd, sif.raw_fd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_vec;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      localparam bit IS_FIRE = (gi == 3);

      logic             out_reg;
      logic             out_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic [CNT_W-1:0] last_cnt;

      // The fire input asserts quickly but releases with the normal debounce length.
      always_comb begin
        last_cnt = DB_LAST;
        if (IS_FIRE && !out_reg) begin
          last_cnt = FA_LAST;
        end
        cnt_next = cnt_reg;
        out_next = out_reg;
        if (sync2_reg[gi] == out_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == last_cnt) begin
          cnt_next = '0;
          out_next = ~out_reg;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_reg <= 1'b0;
          cnt_reg <= '0;
        end else begin
          out_reg <= out_next;
          cnt_reg <= cnt_next;
        end
      end

      assign out_vec[gi] = out_reg;
    end
  endgenerate

  assign sif.sfd = out_vec[0];
  assign sif.srd = out_vec[1];
  assign sif.sw  = out_vec[2];
  assign sif.sfa = out_vec[3];

  logic [6:0] win_reg [4];
  logic [8:0] sum_reg;
  logic [8:0] sum_next;
  logic [1:0] fill_cnt_reg;
  logic       full_reg;
  logic       full_next;
  logic [6:0] st_reg;
  logic       ready_reg;
  logic       fault_reg;
  logic       accept;
  logic       reject;

  assign accept = sif.temp_valid && (sif.raw_temp <= TEMP_MAX);
  assign reject = sif.temp_valid && (sif.raw_temp > TEMP_MAX);

  // The oldest entry is still zero until the window fills, so the running sum
  // stays exact without a separate path for the fill phase.
  assign sum_next  = sum_reg + 9'(sif.raw_temp) - 9'(win_reg[3]);
  assign full_next = full_reg || (fill_cnt_reg == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        win_reg[i] <= '0;
      end
    end else if (accept) begin
      win_reg[0] <= sif.raw_temp;
      for (int i = 1; i < 4; i++) begin
        win_reg[i] <= win_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg      <= '0;
      fill_cnt_reg <= '0;
      full_reg     <= 1'b0;
      st_reg       <= ST_INIT;
      ready_reg    <= 1'b0;
    end else if (accept) begin
      sum_reg <= sum_next;
      if (!full_reg) begin
        fill_cnt_reg <= fill_cnt_reg + 2'd1;
        full_reg     <= full_next;
      end
      if (full_next) begin
        st_reg    <= sum_next[8:2];
        ready_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_reg <= 1'b0;
    end else if (reject) begin
      fault_reg <= 1'b1;
    end
  end

  assign sif.st           = st_reg;
  assign sif.st_ready     = ready_reg;
  assign sif.sensor_fault = fault_reg;

endmodule
